// File: rtl/uart_sink.sv
// uart_sink: buffers one fixed-length message from the UART RX path with a running checksum.
// Optional inter-byte gap timeout is enabled with UART_SINK_TIMEOUT_EN.
module uart_sink #(
  parameter int MESSAGE_LEN = 512,
  parameter int TIMEOUT     = 100000,
  localparam int CW         = $clog2(MESSAGE_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    i_data,
  input  logic          i_valid,
  input  logic [8:0]    i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic [CW-1:0] o_count,
  output logic [31:0]   o_sum,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_dropped,
  output logic          o_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [31:0]   sum_q;
  logic [31:0]   sum_d;
  logic          dropped_q;
  logic          wr_en;
  logic [8:0]    wr_addr;
  logic          timeout_hit;
  logic [7:0]    mem [0:511];
  logic [7:0]    rd_data_q;

  localparam logic [CW-1:0] LAST = CW'(MESSAGE_LEN - 1);

`ifdef UART_SINK_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT + 1);
  logic [GW-1:0] gap_q;

  assign timeout_hit = (state_q == RECV) && !i_valid
                    && (gap_q == GW'(TIMEOUT - 1));

  // Gap counter: counts idle RECV cycles, cleared on bytes and outside RECV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (state_q != RECV || i_valid || timeout_hit) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT;
  assign timeout_hit = 1'b0;
`endif

  // Next-state, write control and count/sum update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    wr_en   = 1'b0;
    wr_addr = 9'(count_q);
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          count_d = CW'(1);
          sum_d   = {24'b0, i_data};
          state_d = RECV;
        end
      end
      RECV: begin
        if (i_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          sum_d   = sum_q + {24'b0, i_data};
          if (count_q == LAST) begin
            state_d = DONE;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, count and checksum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

  // Sticky flag for a byte lost in the DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_q <= 1'b0;
    end else if (state_q == DONE && i_valid) begin
      dropped_q <= 1'b1;
    end
  end

  // Message buffer write port; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= i_data;
    end
  end

  // Registered read port; same-address write returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;
  assign o_count   = count_q;
  assign o_sum     = sum_q;
  assign o_busy    = (state_q == RECV);
  assign o_done    = (state_q == DONE);
  assign o_dropped = dropped_q;
  assign o_timeout = timeout_hit;

endmodule

// File: doc/uart_sink.md
Name: uart_sink

Overview:
- Receive-side counterpart of the message-source block: consumes bytes from the UART receiver, buffers one fixed-length message, and accumulates a running checksum.
- Raises a one-cycle done strobe when the full message has arrived.
- Buffer contents can be read back by a host or testbench through a synchronous read port.
- Sits directly downstream of the UART RX deserializer in the loopback and bring-up designs.

Parameters:
- MESSAGE_LEN, 512: bytes per message; legal range 2..512. Buffer depth is fixed at 512.
- TIMEOUT, 100000: inter-byte gap limit in clk cycles. Used only when UART_SINK_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_data  input  8  received byte; qualified by i_valid.
- i_valid  input  1  one-cycle strobe from the RX deserializer.
- i_rd_addr  input  9  buffer read address.
- o_rd_data  output  8  buffer read data; one-cycle latency.
- o_count  output  $clog2(MESSAGE_LEN+1)  bytes received in current/last message.
- o_sum  output  32  modulo-2^32 sum of bytes in current/last message.
- o_busy  output  1  high while state == RECV.
- o_done  output  1  one-cycle strobe: message complete.
- o_dropped  output  1  sticky: a byte arrived while state == DONE.
- o_timeout  output  1  one-cycle strobe: gap timeout abort; tied 0 without the macro.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state = IDLE; count = 0; sum = 0.
  - o_rd_data = 0; o_busy, o_done, o_dropped, o_timeout all 0.
  - Buffer contents are undefined after reset; no reset is required on the memory.
- States: IDLE, RECV, DONE. o_busy = (state == RECV); o_done = (state == DONE).
- IDLE, i_valid = 1:
  - mem[0] <= i_data; count <= 1; sum <= zero-extended i_data.
  - Next state: RECV.
  - This is the only point where the previous message's count and sum are discarded.
- RECV, i_valid = 1:
  - mem[count] <= i_data; count <= count + 1; sum <= sum + i_data (32-bit wrap, no saturation).
  - If count == MESSAGE_LEN-1 before the increment, next state is DONE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE unconditionally.
  - A byte with i_valid = 1 in DONE is discarded (not written, not summed) and sets o_dropped.
  - o_dropped clears only on reset.
- Hold behaviour:
  - o_count and o_sum hold their final values through DONE and IDLE until the next first byte.
  - A partial message stays visible in o_count/o_sum after a timeout abort.
- Read port:
  - o_rd_data <= mem[i_rd_addr] each cycle (registered).
  - A read and write to the same address in the same cycle returns the old data.
  - Addresses >= MESSAGE_LEN return whatever is stored there; no error.
- i_valid is sampled only as a single-cycle strobe.
  - Back-to-back strobes on consecutive cycles must be accepted, one byte per cycle.
  - Exception: a strobe in the DONE cycle is dropped as above.
- Reset mid-message: everything returns to reset values immediately; there is no resume.

Optional Feature:
- Macro: UART_SINK_TIMEOUT_EN.
- Defined:
  - A gap counter clears on every accepted byte and increments every cycle in RECV without i_valid.
  - When it reaches TIMEOUT-1 with no byte arriving that cycle, state goes to IDLE, o_timeout pulses for one cycle, and o_done stays 0.
  - The gap counter is held at 0 outside RECV.
- Not defined:
  - No gap counter exists; RECV waits indefinitely.
  - o_timeout is a constant 0.

Test Plan:
- MESSAGE_LEN=4; send 0x10,0x20,0x30,0x40 spaced 10 cycles apart:
  - o_done pulses once, in the cycle after the 4th strobe; o_count = 4; o_sum = 0xA0.
  - Reads at addresses 0..3 return 10,20,30,40, each one cycle after the address is presented.
- MESSAGE_LEN=4; four strobes on consecutive cycles, fifth strobe in the DONE cycle:
  - Checksum covers the first four bytes only; o_dropped = 1.
  - A sixth strobe one cycle later starts a new message: o_count = 1.
- Checksum wrap: MESSAGE_LEN=512, all bytes 0xFF -> o_sum = 0x0001FE00, o_count = 512.
- Assert rst_n low after 2 bytes of a 4-byte message:
  - Immediately o_count = 0, o_sum = 0, o_busy = 0.
  - Next 4 bytes complete a fresh message normally.
- With UART_SINK_TIMEOUT_EN, TIMEOUT=50; send 2 bytes, then idle:
  - o_timeout pulses exactly 50 cycles after the 2nd strobe; o_done = 0; state back to IDLE.
  - o_count = 2.
  - A byte at gap 49 instead is accepted and restarts the gap count.
- Without the macro, same idle stimulus for 10000 cycles -> o_busy stays 1, o_timeout stays 0.
